// File: rtl/sdr_init_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
package sdr_init_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_PRE      = 3'd1,
        ST_WAIT_RP  = 3'd2,
        ST_AREF     = 3'd3,
        ST_WAIT_RFC = 3'd4,
        ST_MRS      = 3'd5,
        ST_WAIT_MRD = 3'd6,
        ST_DONE     = 3'd7
    } init_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    // Address bit that selects all banks on PRECHARGE.
    localparam int A10_PRE_ALL = 10;

    // A wait setting of N gives N NOP cycles (0 behaves as 1); the counter
    // value to load is one less because the zero cycle itself is a NOP.
    function automatic logic [3:0] wait_to_load(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd0 : cfg - 4'd1;
    endfunction

endpackage

// File: rtl/sdr_dly_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module sdr_dly_cnt #(
    parameter int              CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority over decrement; reset preloads the power-up delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdr_init_seq.sv
// SDRAM power-up initialization sequencer: power-up wait, PRECHARGE-ALL,
// NUM_AREF AUTO-REFRESH, LOAD MODE REGISTER, then init_done.
//
// state       | meaning
// ------------+------------------------------------------------
// ST_PWRUP    | DESELECT while the power-up delay counts down
// ST_PRE      | PRECHARGE-ALL on the pins for one cycle
// ST_WAIT_RP  | NOP for max(trp,1) cycles
// ST_AREF     | AUTO-REFRESH on the pins for one cycle
// ST_WAIT_RFC | NOP for max(trfc,1) cycles, then AREF again or MRS
// ST_MRS      | LOAD MODE REGISTER with the captured mode value
// ST_WAIT_MRD | NOP for max(tmrd,1) cycles
// ST_DONE     | NOP, init_done high; cfg_reinit restarts at PRE
module sdr_init_seq
    import sdr_init_pkg::*;
#(
    parameter int SDR_BW    = 2,
    parameter int PWRUP_CYC = 20000,
    parameter int NUM_AREF  = 2,
    parameter int CNT_W     = 16
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic [3:0]        cfg_trp,
    input  logic [3:0]        cfg_trfc,
    input  logic [3:0]        cfg_tmrd,
    input  logic [12:0]       cfg_mode_reg,
    input  logic              cfg_reinit,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [12:0]       sdr_addr,
    output logic [SDR_BW-1:0] sdr_dqm,
    output logic [SDR_BW-1:0] sdr_den_n,
    output logic              init_done
);

    localparam int               REF_W      = $clog2(NUM_AREF + 1);
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYC - 1);
    localparam logic [12:0]      ADDR_PRE   = 13'(1) << A10_PRE_ALL;

    init_state_e      state_q;
    logic [3:0]       cmd_q;
    logic [1:0]       ba_q;
    logic [12:0]      addr_q;
    logic             done_q;
    logic [3:0]       trp_q;
    logic [3:0]       trfc_q;
    logic [3:0]       tmrd_q;
    logic [12:0]      mode_q;
    logic [REF_W-1:0] ref_cnt_q;

    logic             cnt_load_d;
    logic             cnt_dec_d;
    logic [CNT_W-1:0] cnt_load_val_d;
    logic             cnt_zero;

    sdr_dly_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_LOAD)
    ) u_dly_cnt (
        .clk_i      (sdram_clk),
        .rst_i      (sdram_rst),
        .load_i     (cnt_load_d),
        .load_val_i (cnt_load_val_d),
        .dec_i      (cnt_dec_d),
        .zero_o     (cnt_zero)
    );

    // Command states arm the delay counter; waiting states count it down.
    always_comb begin
        cnt_load_d     = 1'b0;
        cnt_dec_d      = 1'b0;
        cnt_load_val_d = '0;
        case (state_q)
            ST_PRE: begin
                cnt_load_d     = 1'b1;
                cnt_load_val_d = CNT_W'(wait_to_load(trp_q));
            end
            ST_AREF: begin
                cnt_load_d     = 1'b1;
                cnt_load_val_d = CNT_W'(wait_to_load(trfc_q));
            end
            ST_MRS: begin
                cnt_load_d     = 1'b1;
                cnt_load_val_d = CNT_W'(wait_to_load(tmrd_q));
            end
            ST_PWRUP, ST_WAIT_RP, ST_WAIT_RFC, ST_WAIT_MRD: cnt_dec_d = 1'b1;
            default: ;
        endcase
    end

    // Sequencer FSM with registered pin outputs; config is frozen on PRE entry.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q   <= ST_PWRUP;
            cmd_q     <= CMD_DESEL;
            ba_q      <= 2'b00;
            addr_q    <= '0;
            done_q    <= 1'b0;
            trp_q     <= '0;
            trfc_q    <= '0;
            tmrd_q    <= '0;
            mode_q    <= '0;
            ref_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_PWRUP, ST_DONE: begin
                    if ((state_q == ST_PWRUP && cnt_zero) ||
                        (state_q == ST_DONE && cfg_reinit)) begin
                        state_q   <= ST_PRE;
                        cmd_q     <= CMD_PRE;
                        ba_q      <= 2'b00;
                        addr_q    <= ADDR_PRE;
                        done_q    <= 1'b0;
                        trp_q     <= cfg_trp;
                        trfc_q    <= cfg_trfc;
                        tmrd_q    <= cfg_tmrd;
                        mode_q    <= cfg_mode_reg;
                        ref_cnt_q <= '0;
                    end
                end
                ST_PRE, ST_AREF, ST_MRS: begin
                    state_q <= (state_q == ST_PRE)  ? ST_WAIT_RP  :
                               (state_q == ST_AREF) ? ST_WAIT_RFC : ST_WAIT_MRD;
                    cmd_q   <= CMD_NOP;
                    addr_q  <= '0;
                end
                ST_WAIT_RP, ST_WAIT_RFC: begin
                    if (cnt_zero) begin
                        if (state_q == ST_WAIT_RP || ref_cnt_q < REF_W'(NUM_AREF)) begin
                            state_q   <= ST_AREF;
                            cmd_q     <= CMD_AREF;
                            addr_q    <= '0;
                            ref_cnt_q <= ref_cnt_q + REF_W'(1);
                        end else begin
                            state_q <= ST_MRS;
                            cmd_q   <= CMD_MRS;
                            addr_q  <= mode_q;
                        end
                    end
                end
                ST_WAIT_MRD: begin
                    if (cnt_zero) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_ba    = ba_q;
    assign sdr_addr  = addr_q;
    assign init_done = done_q;
    assign sdr_dqm   = '1;
    assign sdr_den_n = '1;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: two builds (NUM_AREF=2 and NUM_AREF=1) share one
// stimulus stream; a schedule model predicts every pin on every clock.
module tb_sdr_init_seq;

    localparam int PWRUP = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  trp, trfc, tmrd;
    logic [12:0] mode;
    logic        reinit;

    logic        cs_a, ras_a, cas_a, we_a, done_a;
    logic [1:0]  ba_a, dqm_a, den_a;
    logic [12:0] addr_a;
    logic        cs_b, ras_b, cas_b, we_b, done_b;
    logic [1:0]  ba_b, dqm_b, den_b;
    logic [12:0] addr_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdr_init_seq #(.SDR_BW(2), .PWRUP_CYC(PWRUP), .NUM_AREF(2), .CNT_W(16)) dut_a (
        .sdram_clk(clk), .sdram_rst(rst), .cfg_trp(trp), .cfg_trfc(trfc), .cfg_tmrd(tmrd),
        .cfg_mode_reg(mode), .cfg_reinit(reinit), .sdr_cs_n(cs_a), .sdr_ras_n(ras_a),
        .sdr_cas_n(cas_a), .sdr_we_n(we_a), .sdr_ba(ba_a), .sdr_addr(addr_a),
        .sdr_dqm(dqm_a), .sdr_den_n(den_a), .init_done(done_a));

    sdr_init_seq #(.SDR_BW(2), .PWRUP_CYC(PWRUP), .NUM_AREF(1), .CNT_W(16)) dut_b (
        .sdram_clk(clk), .sdram_rst(rst), .cfg_trp(trp), .cfg_trfc(trfc), .cfg_tmrd(tmrd),
        .cfg_mode_reg(mode), .cfg_reinit(reinit), .sdr_cs_n(cs_b), .sdr_ras_n(ras_b),
        .sdr_cas_n(cas_b), .sdr_we_n(we_b), .sdr_ba(ba_b), .sdr_addr(addr_b),
        .sdr_dqm(dqm_b), .sdr_den_n(den_b), .init_done(done_b));

    logic [23:0] obs_a, obs_b;
    assign obs_a = {cs_a, ras_a, cas_a, we_a, ba_a, addr_a, dqm_a, den_a, done_a};
    assign obs_b = {cs_b, ras_b, cas_b, we_b, ba_b, addr_b, dqm_b, den_b, done_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] cmd, input logic [12:0] addr,
                                       input logic done);
        return {cmd, 2'b00, addr, 2'b11, 2'b11, done};
    endfunction

    localparam logic [23:0] EXP_DESEL = {4'b1111, 2'b00, 13'h0, 2'b11, 2'b11, 1'b0};

    // Expected pins at 'off' clocks after the PRE command of a sequence.
    function automatic logic [23:0] seq_pins(input int naref, input int off,
                                             input logic [3:0] t_rp, input logic [3:0] t_rfc,
                                             input logic [3:0] t_mrd, input logic [12:0] md);
        int o, rp, rf, mr;
        rp = (t_rp  == 0) ? 1 : int'(t_rp);
        rf = (t_rfc == 0) ? 1 : int'(t_rfc);
        mr = (t_mrd == 0) ? 1 : int'(t_mrd);
        if (off == 0) return mk(4'b0010, 13'h0400, 1'b0);
        o = off - 1;
        if (o < rp) return mk(4'b0111, 13'h0, 1'b0);
        o -= rp;
        for (int i = 0; i < naref; i++) begin
            if (o == 0) return mk(4'b0001, 13'h0, 1'b0);
            o -= 1;
            if (o < rf) return mk(4'b0111, 13'h0, 1'b0);
            o -= rf;
        end
        if (o == 0) return mk(4'b0000, md, 1'b0);
        o -= 1;
        if (o < mr) return mk(4'b0111, 13'h0, 1'b0);
        return mk(4'b0111, 13'h0, 1'b1);
    endfunction

    int          naref [2] = '{2, 1};
    int          pu    [2];
    int          off   [2];
    logic [3:0]  c_rp  [2];
    logic [3:0]  c_rfc [2];
    logic [3:0]  c_mrd [2];
    logic [12:0] c_md  [2];
    logic [23:0] exp_v [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pu[d]  = PWRUP;
            off[d] = 0;
        end
    endtask

    task automatic capture(input int d);
        c_rp[d]  = trp;
        c_rfc[d] = trfc;
        c_mrd[d] = tmrd;
        c_md[d]  = mode;
        off[d]   = 0;
    endtask

    // One clock: advance the model with the inputs seen at this edge, then
    // compare both builds shortly after the edge.
    task automatic tick();
        logic [23:0] cur;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pu[d] = PWRUP;
            end else if (pu[d] > 0) begin
                pu[d]--;
                if (pu[d] == 0) capture(d);
            end else begin
                cur = seq_pins(naref[d], off[d], c_rp[d], c_rfc[d], c_mrd[d], c_md[d]);
                if (cur[0] && reinit) capture(d);
                else if (off[d] < 1000) off[d]++;
            end
            exp_v[d] = (rst || pu[d] > 0) ? EXP_DESEL :
                       seq_pins(naref[d], off[d], c_rp[d], c_rfc[d], c_mrd[d], c_md[d]);
        end
        #1;
        chk("pins_a", obs_a, exp_v[0]);
        chk("pins_b", obs_b, exp_v[1]);
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_a", obs_a, EXP_DESEL);
        chk("rst_async_b", obs_b, EXP_DESEL);
        for (int i = 0; i < hold; i++) tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [12:0] m);
        trp = a; trfc = b; tmrd = c; mode = m;
    endtask

    initial begin
        rst = 1'b1;
        reinit = 1'b0;
        set_cfg(4'd2, 4'd4, 4'd2, 13'h0033);
        model_reset();

        // Nominal power-up sequence.
        apply_reset(2);
        repeat (31) tick();

        // Reinit from DONE: no power-up wait, full command timing repeats.
        reinit = 1'b1; tick(); reinit = 1'b0;
        repeat (24) tick();

        // Zero wait settings behave as one NOP each.
        set_cfg(4'd0, 4'd0, 4'd0, 13'h1abc);
        apply_reset(2);
        repeat (24) tick();

        // Reset in the middle of the refresh wait.
        set_cfg(4'd2, 4'd4, 4'd2, 13'h0033);
        apply_reset(2);
        repeat (15) tick();
        apply_reset(3);
        repeat (30) tick();

        // Reinit outside DONE is ignored; trfc change after capture has no effect.
        apply_reset(2);
        repeat (11) tick();
        reinit = 1'b1; trfc = 4'd7; tick(); reinit = 1'b0;
        repeat (30) tick();

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) trp  = 4'($urandom_range(5));
            if ($urandom_range(9) == 0) trfc = 4'($urandom_range(6));
            if ($urandom_range(9) == 0) tmrd = 4'($urandom_range(5));
            if ($urandom_range(9) == 0) mode = 13'($urandom);
            reinit = ($urandom_range(5) == 0);
            if ($urandom_range(399) == 0) apply_reset(int'($urandom_range(3)) + 1);
            else tick();
            reinit = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdr_init_seq.md
Name: sdr_init_seq

Overview:
- Power-up initialization sequencer for the 16-bit SDRAM controller; drives the controller-side pin group of the SDRAM bus (command, address, bank, mask, output enable) until the device is initialized.
- Sequence: power-up wait, PRECHARGE-ALL, NUM_AREF AUTO-REFRESH, LOAD MODE REGISTER, then init_done.
- Downstream command logic takes the pins only once init_done=1; the muxing is outside this block.

Parameters:
- SDR_BW, 2, SDRAM byte width; sets the sdr_dqm and sdr_den_n width.
- PWRUP_CYC, 20000, power-up wait in clocks (100 us at 200 MHz); must be >=2.
- NUM_AREF, 2, number of AUTO-REFRESH commands; must be >=1.
- CNT_W, 16, delay counter width; must satisfy 2^CNT_W > PWRUP_CYC.

Ports:
- sdram_clk  in  1  SDRAM controller clock.
- sdram_rst  in  1  reset, asynchronous, active-high.
- cfg_trp  in  4  precharge-to-command NOP cycles; 0 treated as 1.
- cfg_trfc  in  4  refresh-to-command NOP cycles; 0 treated as 1.
- cfg_tmrd  in  4  mode-load-to-command NOP cycles; 0 treated as 1.
- cfg_mode_reg  in  13  value driven on sdr_addr during LOAD MODE.
- cfg_reinit  in  1  single-cycle pulse; restarts the sequence from PRECHARGE. Honoured only in DONE.
- sdr_cs_n  out  1  chip select.
- sdr_ras_n  out  1  RAS.
- sdr_cas_n  out  1  CAS.
- sdr_we_n  out  1  write enable.
- sdr_ba  out  2  bank address.
- sdr_addr  out  13  row/mode address.
- sdr_dqm  out  SDR_BW  data mask.
- sdr_den_n  out  SDR_BW  data output enable, active-low.
- init_done  out  1  high while in DONE.

Behaviour:
- All outputs are registered.
- Reset values, and values for the whole PWRUP state:
  - cs_n=ras_n=cas_n=we_n=1 (DESELECT).
  - ba=0, addr=0.
  - dqm all 1; den_n all 1.
  - init_done=0.
- dqm and den_n stay all 1 in every state; this block never drives data.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP = 0111.
  - PRE = 0010, with addr[10]=1, other addr bits 0, ba=0.
  - AREF = 0001, addr=0.
  - MRS = 0000, ba=0, addr=cfg_mode_reg.
- FSM states: PWRUP, PRE, WAIT_RP, AREF, WAIT_RFC, MRS, WAIT_MRD, DONE.
- PWRUP:
  - The delay counter is loaded with PWRUP_CYC-1 by reset and decrements each clock.
  - At 0 the FSM goes to PRE, so the PRE command occupies clock PWRUP_CYC, counting the first rising edge after reset release as clock 0.
- Each command state (PRE, AREF, MRS):
  - Drives its command for exactly 1 cycle.
  - Loads the delay counter with max(cfg,1)-1, using cfg_trp, cfg_trfc or cfg_tmrd respectively.
- Each WAIT state drives NOP for max(cfg,1) cycles, then moves on:
  - WAIT_RP -> AREF.
  - WAIT_RFC -> AREF while the refresh count is < NUM_AREF, else MRS.
  - WAIT_MRD -> DONE.
- cfg_trp, cfg_trfc, cfg_tmrd and cfg_mode_reg are captured into internal registers on entry to PRE. Later changes do not affect a sequence in progress.
- DONE:
  - init_done=1, registered, in the first DONE cycle.
  - Pins show NOP.
- cfg_reinit in DONE:
  - Next cycle: state PRE, init_done=0, PRE on the pins in that same cycle.
  - Refresh count is cleared.
  - The power-up wait is not repeated.
- cfg_reinit in any other state: ignored, not queued.
- sdram_rst asserted mid-sequence: immediate return to PWRUP reset values, and the full power-up wait is repeated.
- Counter width and arithmetic:
  - The refresh counter has width $clog2(NUM_AREF+1).
  - The delay counter never wraps; it is reloaded before any decrement below 0.

Decomposition:
- Package sdr_init_pkg:
  - init_state_e enum.
  - 4-bit command constants CMD_NOP, CMD_PRE, CMD_AREF, CMD_MRS, CMD_DESEL.
  - A10_PRE_ALL index constant.
- One sub-module, sdr_dly_cnt: loadable CNT_W down-counter with a zero flag.

Test Plan:
- Setup for scenarios 1-4 and 6: PWRUP_CYC=10, NUM_AREF=2, trp=2, trfc=4, tmrd=2, mode=13'h0033. Release reset -> expected pins:
  - DESELECT on clocks 0-9.
  - PRE (addr=0x400) on clock 10, NOP on 11-12.
  - AREF on 13, NOP on 14-17.
  - AREF on 18, NOP on 19-22.
  - MRS with addr=0x033 on 23, NOP on 24-25.
  - init_done=1 from clock 26.
  - dqm=2'b11 and den_n=2'b11 throughout.
- trp=trfc=tmrd=0 -> each wait is 1 NOP: PRE@10, AREF@12, AREF@14, MRS@16, init_done@18.
- Assert sdram_rst at clock 15 (in WAIT_RFC) -> all outputs return to reset values immediately; after release, PRE again appears exactly 10 clocks later.
- cfg_reinit pulse 5 clocks after init_done -> init_done falls and PRE appears next clock; full PRE/AREF/AREF/MRS timing repeats with no power-up wait; init_done returns 16 clocks after PRE.
- cfg_reinit pulse at clock 12 (WAIT_RP), plus cfg_trfc changed to 7 at clock 12 -> reinit pulse ignored; the rest of the sequence still uses trfc=4.
- NUM_AREF=1 build -> exactly one AREF; MRS at clock 18.
